// File: rtl/nn_host_pkg.sv
// Shared definitions for the neural-network host port.
//   state_t  : host-port sequencing states
//   DEF_*    : default sample width and frame sizes
//   addr_w() : address width needed to index a buffer of a given depth (min 1)
package nn_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_N_IN  = 2;
  localparam int unsigned DEF_N_OUT = 1;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/nn_sample_buf.sv
// DW x DEPTH register file, one synchronous write port and one combinational
// read port. Out-of-range writes are dropped; out-of-range reads return 0.
//   clk         : write clock
//   we/waddr/wdata : write port
//   raddr/rdata : combinational read port
module nn_sample_buf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;

  assign widx = waddr[IW-1:0];
  assign ridx = raddr[IW-1:0];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) mem[widx] <= wdata;
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[ridx] : '0;

endmodule

// File: rtl/nn_host_port.sv
// Host-side port for the generated neural-network top. Buffers one frame of
// host samples, drives the fill/req handshake, serves the network's serial
// input-read channel, captures its serial output-write channel and flags done.
//   clk, rst (async, active-low)
//   in_valid/in_data/in_ready : host sample stream
//   start, clear              : host control pulses
//   req, fill, ack_fill, ack_network : network handshake
//   rd_trig/rd_addr/rd_data   : network input-read channel (1-cycle latency)
//   wr_trig/wr_addr/wr_data   : network output-write channel
//   res_addr/res_data         : host result read (combinational)
//   busy, done, err           : status; err is sticky until reset
module nn_host_port
  import nn_host_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned N_IN   = DEF_N_IN,
  parameter int unsigned N_OUT  = DEF_N_OUT,
  parameter int unsigned AW_IN  = addr_w(N_IN),
  parameter int unsigned AW_OUT = addr_w(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic              start,
  input  logic              clear,
  output logic              req,
  output logic              fill,
  input  logic              ack_fill,
  input  logic              ack_network,
  input  logic              rd_trig,
  input  logic [AW_IN-1:0]  rd_addr,
  output logic [DW-1:0]     rd_data,
  input  logic              wr_trig,
  input  logic [AW_OUT-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic [AW_OUT-1:0] res_addr,
  output logic [DW-1:0]     res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned ICW = $clog2(N_IN + 1);
  localparam int unsigned OCW = $clog2(N_OUT + 1);
  localparam logic [ICW-1:0] IN_FULL  = ICW'(N_IN);
  localparam logic [OCW-1:0] OUT_FULL = OCW'(N_OUT);

  state_t         state, state_nxt;
  logic [ICW-1:0] in_cnt;
  logic [OCW-1:0] out_cnt;
  logic [DW-1:0]  ibuf_rdata;
  logic [DW-1:0]  obuf_rdata;

  logic loading, accept, start_ok, start_bad;
  logic rd_ok, rd_bad, wr_ok, wr_bad, ack_short;

  assign loading  = (state == IDLE) || (state == LOAD);
  // Gated by rst so the port reads 0 while reset is held.
  assign in_ready = rst && loading && (in_cnt < IN_FULL);

  // clear outranks every other event, so all side effects are masked by it.
  always_comb begin
    accept    = in_valid && in_ready && !clear;
    start_ok  = start && (state == LOAD) && (in_cnt == IN_FULL);
    start_bad = start && loading && (in_cnt != IN_FULL);
    rd_ok     = rd_trig && (state == FILL);
    rd_bad    = rd_trig && !(rd_ok && (32'(rd_addr) < N_IN));
    wr_ok     = wr_trig && ((state == FILL) || (state == RUN)) && (32'(wr_addr) < N_OUT);
    wr_bad    = wr_trig && !wr_ok;
    ack_short = ack_network && (state == RUN) && (out_cnt != OUT_FULL);

    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = LOAD;
        LOAD:    if (start_ok) state_nxt = FILL;
        FILL:    if (ack_fill) state_nxt = RUN;
        RUN:     if (ack_network) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      req     <= 1'b0;
      fill    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      req   <= (state_nxt == FILL) || (state_nxt == RUN);
      busy  <= (state_nxt == FILL) || (state_nxt == RUN);
      fill  <= (state_nxt == FILL);
      done  <= (state_nxt == DONE);
      if (clear) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (accept) in_cnt <= in_cnt + 1'b1;
        if (wr_ok && (out_cnt != OUT_FULL)) out_cnt <= out_cnt + 1'b1;
        // ibuf returns 0 for an out-of-range address.
        if (rd_ok) rd_data <= ibuf_rdata;
        if (start_bad || rd_bad || wr_bad || ack_short) err <= 1'b1;
      end
    end
  end

  nn_sample_buf #(
    .DW    (DW),
    .DEPTH (N_IN),
    .AW    (AW_IN)
  ) ibuf (
    .clk   (clk),
    .we    (accept),
    .waddr (AW_IN'(in_cnt)),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (ibuf_rdata)
  );

  nn_sample_buf #(
    .DW    (DW),
    .DEPTH (N_OUT),
    .AW    (AW_OUT)
  ) obuf (
    .clk   (clk),
    .we    (wr_ok && !clear),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (res_addr),
    .rdata (obuf_rdata)
  );

  assign res_data = rst ? obuf_rdata : '0;

endmodule
